// File: rtl/data_sram_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_unit
// Description : Single-port 64-bit data memory with a synchronous write and a
//               registered, held read port. DATA_SRAM_CLEAR_ON_RESET_EN adds an
//               asynchronous clear of the whole array on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module data_sram_unit #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_sram_en,
  input  logic        data_sram_wen,
  input  logic [63:0] data_sram_addr,
  input  logic [63:0] data_sram_wdata,
  output logic [63:0] data_sram_rdata
);

  logic [63:0]   r_mem [0:DEPTH-1];
  logic [63:0]   r_rdata;
  logic [AW-1:0] w_idx;
  logic          w_rd;
  logic          w_unused_addr;

  assign w_idx = data_sram_addr[AW-1:0];
  // Upper address bits alias modulo DEPTH and are deliberately dropped.
  assign w_unused_addr = ^data_sram_addr[63:AW];
  // A simultaneous write wins the cycle; the read port holds.
  assign w_rd  = data_sram_en & ~data_sram_wen;

`ifdef DATA_SRAM_CLEAR_ON_RESET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 64'h0;
      end
    end else if (data_sram_wen) begin
      r_mem[w_idx] <= data_sram_wdata;
    end
  end
`else
  // No reset on the array so it can map onto a RAM macro; rst_n only gates
  // the write enable so writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && data_sram_wen) begin
      r_mem[w_idx] <= data_sram_wdata;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 64'h0;
    end else if (w_rd) begin
      r_rdata <= r_mem[w_idx];
    end
  end

  assign data_sram_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sram_unit
// Description : Self-checking bench for data_sram_unit using a reference
//               memory model and a queue of expected read results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_unit;

  logic        clk;
  logic        rst_n;
  logic        data_sram_en;
  logic        data_sram_wen;
  logic [63:0] data_sram_addr;
  logic [63:0] data_sram_wdata;
  logic [63:0] data_sram_rdata;

  int checks;
  int errors;

  logic [63:0] model [int];
  logic [63:0] exp_q [$];
  logic [63:0] exp_v;
  logic [63:0] held;

  data_sram_unit #(.DEPTH(256)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle on the falling edge; return 1 ns after the rising edge.
  task automatic cycle(input logic en, input logic wen,
                       input logic [63:0] addr, input logic [63:0] wdata);
    @(negedge clk);
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    if (rst_n && wen) model[int'(addr[7:0])] = wdata;
    if (rst_n && en && !wen) exp_q.push_back(model[int'(addr[7:0])]);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    data_sram_en = 1'b0;
    data_sram_wen = 1'b0;
    data_sram_addr = 64'h0;
    data_sram_wdata = 64'h0;
    #12;
    checks++;
    if (data_sram_rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h want %h", data_sram_rdata, 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    cycle(1'b0, 1'b1, 64'd2, 64'd22);
    cycle(1'b1, 1'b1, 64'd8, 64'd23);
    cycle(1'b1, 1'b0, 64'd2, 64'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp_v || exp_v !== 64'd22) begin
      errors++;
      $display("FAIL write_read_2 got %h want %h", data_sram_rdata, 64'd22);
    end
    cycle(1'b1, 1'b0, 64'd8, 64'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp_v) begin
      errors++;
      $display("FAIL write_read_8 got %h want %h", data_sram_rdata, exp_v);
    end
  endtask

  task automatic test_hold();
    held = 64'd23;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 64'd2, 64'd0);
      checks++;
      if (data_sram_rdata !== held) begin
        errors++;
        $display("FAIL hold_%0d got %h want %h", i, data_sram_rdata, held);
      end
    end
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, 1'b1, 64'd2, 64'd99);
    checks++;
    if (data_sram_rdata !== 64'd23) begin
      errors++;
      $display("FAIL simul_hold got %h want %h", data_sram_rdata, 64'd23);
    end
    cycle(1'b1, 1'b0, 64'd2, 64'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== 64'd99 || exp_v !== 64'd99) begin
      errors++;
      $display("FAIL simul_read got %h want %h", data_sram_rdata, 64'd99);
    end
  endtask

  task automatic test_alias();
    cycle(1'b0, 1'b1, 64'h1_0000_0005, 64'hDEAD_BEEF_0000_0001);
    cycle(1'b1, 1'b0, 64'd5, 64'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== 64'hDEAD_BEEF_0000_0001) begin
      errors++;
      $display("FAIL alias got %h want %h", data_sram_rdata, 64'hDEAD_BEEF_0000_0001);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b1, 64'd9, 64'h1234);
    cycle(1'b1, 1'b0, 64'd2, 64'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp_v) begin
      errors++;
      $display("FAIL pre_reset_read got %h want %h", data_sram_rdata, exp_v);
    end
    // Pulse reset mid-cycle with a write pending that must be suppressed.
    #2;
    data_sram_en = 1'b0;
    data_sram_wen = 1'b1;
    data_sram_addr = 64'd9;
    data_sram_wdata = 64'hBAD;
    rst_n = 1'b0;
    #1;
    checks++;
    if (data_sram_rdata !== 64'h0) begin
      errors++;
      $display("FAIL async_reset_rdata got %h want %h", data_sram_rdata, 64'h0);
    end
`ifdef DATA_SRAM_CLEAR_ON_RESET_EN
    foreach (model[k]) model[k] = 64'h0;
`endif
    @(posedge clk);
    @(negedge clk);
    data_sram_wen = 1'b0;
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 64'd2, 64'd0);
    exp_v = exp_q.pop_front();
    checks++;
`ifdef DATA_SRAM_CLEAR_ON_RESET_EN
    if (data_sram_rdata !== 64'h0) begin
      errors++;
      $display("FAIL post_reset_2 got %h want %h", data_sram_rdata, 64'h0);
    end
`else
    if (data_sram_rdata !== 64'd99) begin
      errors++;
      $display("FAIL post_reset_2 got %h want %h", data_sram_rdata, 64'd99);
    end
`endif
    cycle(1'b1, 1'b0, 64'd9, 64'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp_v) begin
      errors++;
      $display("FAIL reset_write_suppressed got %h want %h", data_sram_rdata, exp_v);
    end
  endtask

  task automatic test_boundary();
    cycle(1'b0, 1'b1, 64'd255, 64'hFFFF_FFFF_FFFF_FFFF);
    cycle(1'b0, 1'b1, 64'd0, 64'h1);
    cycle(1'b1, 1'b0, 64'd255, 64'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL boundary_255 got %h want %h", data_sram_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    cycle(1'b1, 1'b0, 64'd0, 64'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== 64'h1) begin
      errors++;
      $display("FAIL boundary_0 got %h want %h", data_sram_rdata, 64'h1);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a;
    logic [63:0] d;
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      a = {$urandom, 28'h0, 4'(i)};
      cycle(1'b0, 1'b1, a, d);
    end
    for (int i = 0; i < 40; i++) begin
      a = {32'h0, $urandom} & 64'h0000_00FF_0000_000F;
      if ($urandom_range(0, 2) == 0) begin
        d = {$urandom, $urandom};
        cycle(1'b0, 1'b1, a, d);
      end else begin
        cycle(1'b1, 1'b0, a, 64'd0);
        exp_v = exp_q.pop_front();
        checks++;
        if (data_sram_rdata !== exp_v) begin
          errors++;
          $display("FAIL b2b_%0d got %h want %h", i, data_sram_rdata, exp_v);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_hold();
    test_simultaneous();
    test_alias();
    test_async_reset();
    test_boundary();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
